// File: rtl/pipe_pkg.sv
// Shared definitions for the fixed-latency pipeline receive path:
// default beat width, the beat type and the credit-counter width helper.
package pipe_pkg;

    localparam int unsigned DATA_W = 32;

    typedef logic [DATA_W-1:0] beat_t;

    // Width needed to hold every value from 0 to depth inclusive.
    function automatic int unsigned credit_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// In-order FIFO of DEPTH entries with wrap-around pointers that work for any DEPTH >= 2.
// A write while full with no simultaneous read is dropped and flagged.
module sync_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic         overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = credit_w(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_rd;
    logic w_wr;

    assign full     = (r_count == CW'(DEPTH));
    assign empty    = (r_count == '0);
    assign w_rd     = rd_en && !empty;
    // A read in the same cycle frees the slot, so a write when full is still legal then.
    assign w_wr     = wr_en && (!full || w_rd);
    assign overflow = wr_en && full && !w_rd;
    assign rd_data  = empty ? '0 : r_mem[r_rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_credit_sink.sv
// Receiver at the exit of a non-stallable pipeline: grants issue credits,
// buffers exiting beats and presents them on a valid/ready handshake.
module pipe_credit_sink
    import pipe_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue,
    output logic                          issue_ok,
    input  logic                          pipe_valid,
    input  logic [W-1:0]                  pipe_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [W-1:0]                  out_data,
    output logic [credit_w(DEPTH)-1:0]    credits,
    output logic                          err
);

    localparam int CW = credit_w(DEPTH);

    // Handshake: a beat transfers downstream on any rising edge where
    // out_valid && out_ready; out_data holds while out_valid && !out_ready.
    logic [CW-1:0] r_credits;
    logic          r_err;
    logic          w_consume;
    logic          w_return;
    logic          w_empty;
    logic          w_full;
    logic          w_overflow;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (pipe_valid),
        .wr_data  (pipe_data),
        .rd_en    (out_ready),
        .rd_data  (out_data),
        .full     (w_full),
        .empty    (w_empty),
        .overflow (w_overflow)
    );

    assign issue_ok  = (r_credits != '0);
    assign out_valid = !w_empty;
    assign w_consume = issue && issue_ok;
    assign w_return  = out_valid && out_ready;
    assign credits   = r_credits;
    assign err       = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= CW'(DEPTH);
            r_err     <= 1'b0;
        end else begin
            // Returns are clamped at DEPTH so stray beats cannot mint credit.
            if (w_return && !w_consume && (r_credits != CW'(DEPTH))) begin
                r_credits <= r_credits + 1'b1;
            end else if (w_consume && !w_return) begin
                r_credits <= r_credits - 1'b1;
            end
            if ((issue && !issue_ok) || w_overflow) begin
                r_err <= 1'b1;
            end
        end
    end

    logic w_unused;
    assign w_unused = w_full;

endmodule
